// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two byte requesters.
// Optional watchdog on the transmitter handshake enabled by defining ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_1,
  input  logic [DATA_W-1:0] datain_1,
  output logic              ack_1,
  input  logic              req_2,
  input  logic [DATA_W-1:0] datain_2,
  output logic              ack_2,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              err
);

  localparam int unsigned GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t            r_state, w_state_n;
  logic [GAP_W-1:0]  r_gap_cnt, w_gap_cnt_n;
  logic              r_last, w_last_n;  // 0 = ch1 served last, 1 = ch2
  logic              w_ack_1_n, w_ack_2_n, w_tx_start_n, w_err_n, w_busy_n;
  logic [1:0]        w_grant_n;
  logic [DATA_W-1:0] w_tx_data_n;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_wd_cnt, w_wd_cnt_n;
  logic            w_wd_expired;

  assign w_wd_expired = (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) r_wd_cnt <= '0;
    else     r_wd_cnt <= w_wd_cnt_n;
  end
`else
  logic w_unused_timeout;
  assign w_unused_timeout = |TIMEOUT_CYCLES;
`endif

  // Next-state and registered-output values
  always_comb begin
    w_state_n    = r_state;
    w_gap_cnt_n  = r_gap_cnt;
    w_last_n     = r_last;
    w_grant_n    = grant;
    w_tx_data_n  = tx_data;
    w_ack_1_n    = 1'b0;
    w_ack_2_n    = 1'b0;
    w_tx_start_n = 1'b0;
    w_err_n      = 1'b0;
`ifdef ARB_TIMEOUT_EN
    w_wd_cnt_n   = r_wd_cnt + WD_W'(1);
`endif

    case (r_state)
      S_IDLE: begin
`ifdef ARB_TIMEOUT_EN
        w_wd_cnt_n = '0;
`endif
        // Tie goes to the channel not served last
        if (req_1 && (!req_2 || r_last)) begin
          w_ack_1_n    = 1'b1;
          w_tx_start_n = 1'b1;
          w_tx_data_n  = datain_1;
          w_grant_n    = 2'b01;
          w_state_n    = S_WAIT_BUSY;
        end else if (req_2) begin
          w_ack_2_n    = 1'b1;
          w_tx_start_n = 1'b1;
          w_tx_data_n  = datain_2;
          w_grant_n    = 2'b10;
          w_state_n    = S_WAIT_BUSY;
        end
      end

      S_WAIT_BUSY: begin
        if (tx_busy) begin
          w_state_n = S_WAIT_DONE;
`ifdef ARB_TIMEOUT_EN
          w_wd_cnt_n = '0;
        end else if (w_wd_expired) begin
          w_err_n   = 1'b1;
          w_last_n  = grant[1];
          w_grant_n = 2'b00;
          w_state_n = S_IDLE;
`endif
        end
      end

      S_WAIT_DONE: begin
        if (!tx_busy) begin
          w_last_n  = grant[1];
          w_grant_n = 2'b00;
          if (GAP_CYCLES == 0) begin
            w_state_n = S_IDLE;
          end else begin
            w_gap_cnt_n = GAP_W'(GAP_CYCLES);
            w_state_n   = S_GAP;
          end
`ifdef ARB_TIMEOUT_EN
        end else if (w_wd_expired) begin
          w_err_n   = 1'b1;
          w_last_n  = grant[1];
          w_grant_n = 2'b00;
          w_state_n = S_IDLE;
`endif
        end
      end

      S_GAP: begin
        w_gap_cnt_n = r_gap_cnt - GAP_W'(1);
        if (r_gap_cnt <= GAP_W'(1)) w_state_n = S_IDLE;
      end

      default: w_state_n = S_IDLE;
    endcase

    w_busy_n = (w_state_n != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_gap_cnt <= '0;
      r_last    <= 1'b1;
      ack_1     <= 1'b0;
      ack_2     <= 1'b0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      grant     <= 2'b00;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_gap_cnt <= w_gap_cnt_n;
      r_last    <= w_last_n;
      ack_1     <= w_ack_1_n;
      ack_2     <= w_ack_2_n;
      tx_start  <= w_tx_start_n;
      tx_data   <= w_tx_data_n;
      grant     <= w_grant_n;
      busy      <= w_busy_n;
      err       <= w_err_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scoreboard bench for uart_tx_arbiter with a simple UART TX busy model.
// Define ARB_TIMEOUT_EN to exercise the watchdog path instead of the unbounded wait.
module tb_uart_tx_arbiter;

  localparam int unsigned DW  = 8;
  localparam int unsigned GAP = 2;
  localparam int unsigned TO  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_1 = 1'b0, req_2 = 1'b0;
  logic [DW-1:0] datain_1 = '0, datain_2 = '0;
  logic          ack_1, ack_2, tx_start, busy, err;
  logic [DW-1:0] tx_data;
  logic [1:0]    grant;
  logic          tx_busy = 1'b0;
  logic          tx_en = 1'b1;
  int            tx_rem = 0;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]    g;
    logic [DW-1:0] d;
  } exp_t;
  exp_t exp_q[$];

  uart_tx_arbiter #(.DATA_W(DW), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req_1(req_1), .datain_1(datain_1), .ack_1(ack_1),
    .req_2(req_2), .datain_2(datain_2), .ack_2(ack_2),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant(grant), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // UART TX model: busy one cycle after tx_start, for 10 cycles
  always @(posedge clk) begin
    if (tx_start && tx_en) begin
      tx_busy <= 1'b1;
      tx_rem  <= 10;
    end else if (tx_rem > 1) begin
      tx_rem <= tx_rem - 1;
    end else if (tx_rem == 1) begin
      tx_rem  <= 0;
      tx_busy <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every tx_start pops one expected grant
  logic prev_start = 1'b0;
  always @(negedge clk) begin
    if (tx_start) begin
      check("start_width", 32'(prev_start), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_start", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("tx_data", 32'(tx_data), 32'(e.d));
        check("grant", 32'(grant), 32'(e.g));
        check("acks", 32'({ack_2, ack_1}), 32'(e.g));
      end
    end else if (ack_1 || ack_2) begin
      check("ack_without_start", 32'({ack_2, ack_1}), 32'd0);
    end
    prev_start = tx_start;
  end

  task automatic wait_start(input int budget, output int cycles);
    bit found = 0;
    cycles = 0;
    while (!found && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (tx_start) found = 1;
    end
    check("start_timeout", 32'(found), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (!busy) found = 1;
    end
    check("idle_timeout", 32'(found), 32'd1);
  endtask

  initial begin
    int cyc;
    logic [1:0] prev_g;

    // Reset held with a pending request
    req_1 = 1'b1; datain_1 = 8'h5A;
    exp_q.push_back('{2'b01, 8'h5A});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_outs", 32'({ack_1, ack_2, tx_start, grant, busy, err}), 32'd0);
      check("rst_data", 32'(tx_data), 32'd0);
    end
    rst = 1'b0;
    wait_start(10, cyc);
    check("post_rst_latency", 32'(cyc), 32'd1);
    req_1 = 1'b0;
    wait_idle(40);

    // Single request and gap timing
    @(negedge clk);
    req_1 = 1'b1; datain_1 = 8'b1000_0011;
    exp_q.push_back('{2'b01, 8'h83});
    wait_start(10, cyc);
    check("single_latency", 32'(cyc), 32'd1);
    req_1 = 1'b0;
    for (int i = 0; i < 20 && !tx_busy; i++) @(negedge clk);
    for (int i = 0; i < 20 && tx_busy; i++) @(negedge clk);
    cyc = 0;
    while (busy && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("busy_fall_delay", 32'(cyc), 32'(GAP + 1));

    // Tie right after reset: ch1 first
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    req_1 = 1'b1; datain_1 = 8'hF0;
    req_2 = 1'b1; datain_2 = 8'hAA;
    exp_q.push_back('{2'b01, 8'hF0});
    exp_q.push_back('{2'b10, 8'hAA});
    wait_start(10, cyc);
    req_1 = 1'b0;
    wait_start(40, cyc);
    check("ch2_after_frame_gap", 32'(cyc > 12), 32'd1);
    req_2 = 1'b0;
    wait_idle(40);

    // Fairness with both held
    @(negedge clk);
    req_1 = 1'b1; datain_1 = 8'h07;
    req_2 = 1'b1; datain_2 = 8'h55;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back('{2'b01, 8'h07});
      exp_q.push_back('{2'b10, 8'h55});
    end
    prev_g = 2'b00;
    for (int i = 0; i < 4; i++) begin
      wait_start(40, cyc);
      check("alternate", 32'(grant == prev_g), 32'd0);
      prev_g = grant;
    end
    req_1 = 1'b0; req_2 = 1'b0;
    wait_idle(40);

    // Reset while in WAIT_DONE
    @(negedge clk);
    req_1 = 1'b1; datain_1 = 8'h11;
    req_2 = 1'b1; datain_2 = 8'h22;
    exp_q.push_back('{2'b01, 8'h11});
    wait_start(10, cyc);
    req_1 = 1'b0;
    for (int i = 0; i < 20 && !tx_busy; i++) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_grant_busy", 32'({grant, busy}), 32'd0);
    check("midrst_pulses", 32'({ack_1, ack_2, tx_start}), 32'd0);
    rst = 1'b0;
    exp_q.push_back('{2'b10, 8'h22});
    wait_start(10, cyc);
    check("midrst_regrant_latency", 32'(cyc), 32'd1);
    req_2 = 1'b0;
    wait_idle(60);

    // Transmitter that never asserts busy
    for (int i = 0; i < 20 && tx_busy; i++) @(negedge clk);
    tx_en = 1'b0;
    @(negedge clk);
    req_1 = 1'b1; datain_1 = 8'h3C;
    exp_q.push_back('{2'b01, 8'h3C});
    wait_start(10, cyc);
    req_1 = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cyc = 0;
    while (!err && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("timeout_cycles", 32'(cyc), 32'(TO));
    @(negedge clk);
    check("timeout_err_width", 32'(err), 32'd0);
    check("timeout_idle", 32'({busy, grant}), 32'd0);
`else
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("stuck_err", 32'(err), 32'd0);
      check("stuck_busy", 32'({busy, grant}), 32'b101);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    tx_en = 1'b1;
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
